// File: rtl/rns_forward_converter.sv
// Bit-serial binary-to-residue converter: in_data mod three 3-bit moduli.
// Ports: clk, rst_n (sync, low), in_valid/in_ready/in_data/moduli_a..c in, out_valid/out_ready/res_a..c/err out.
module rns_forward_converter #(
  parameter int W_IN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_IN-1:0] in_data,
  input  logic [2:0]      moduli_a,
  input  logic [2:0]      moduli_b,
  input  logic [2:0]      moduli_c,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      res_a,
  output logic [2:0]      res_b,
  output logic [2:0]      res_c,
  output logic            err
);

  localparam int CW = (W_IN > 1) ? $clog2(W_IN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [W_IN-1:0] sh;
  logic [CW-1:0]   cnt;
  logic [2:0]      mod_a;
  logic [2:0]      mod_b;
  logic [2:0]      mod_c;
  logic [3:0]      r_a;
  logic [3:0]      r_b;
  logic [3:0]      r_c;
  logic [3:0]      nr_a;
  logic [3:0]      nr_b;
  logic [3:0]      nr_c;
  logic            err_q;

  // One restoring step: shift in the next operand bit, subtract once.
  function automatic logic [3:0] step(
    input logic [3:0] r,
    input logic       b,
    input logic [2:0] m
  );
    logic [3:0] t;
    t = {r[2:0], 1'b0} + {3'b000, b};
    return (t >= {1'b0, m}) ? t - {1'b0, m} : t;
  endfunction

  // A zero modulus never reduces, so its remainder is meaningless.
  function automatic logic [2:0] fin(
    input logic [3:0] r,
    input logic [2:0] m
  );
    return (m == 3'd0) ? 3'd0 : r[2:0];
  endfunction

  always_comb begin
    nr_a = step(r_a, sh[W_IN-1], mod_a);
    nr_b = step(r_b, sh[W_IN-1], mod_b);
    nr_c = step(r_c, sh[W_IN-1], mod_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sh        <= '0;
      cnt       <= '0;
      mod_a     <= 3'd0;
      mod_b     <= 3'd0;
      mod_c     <= 3'd0;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_c       <= 4'd0;
      err_q     <= 1'b0;
      res_a     <= 3'd0;
      res_b     <= 3'd0;
      res_c     <= 3'd0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sh       <= in_data;
            mod_a    <= moduli_a;
            mod_b    <= moduli_b;
            mod_c    <= moduli_c;
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_c      <= 4'd0;
            cnt      <= CW'(W_IN - 1);
            err_q    <= (moduli_a == 3'd0) |
                        (moduli_b == 3'd0) |
                        (moduli_c == 3'd0);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          r_a <= nr_a;
          r_b <= nr_b;
          r_c <= nr_c;
          sh  <= sh << 1;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            res_a     <= fin(nr_a, mod_a);
            res_b     <= fin(nr_b, mod_b);
            res_c     <= fin(nr_c, mod_c);
            err       <= err_q;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rns_forward_converter.sv
// Directed bench for rns_forward_converter.
// Checks latency, residues, err, backpressure and reset abort.
module tb_rns_forward_converter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic [2:0] moduli_a = 3'd0;
  logic [2:0] moduli_b = 3'd0;
  logic [2:0] moduli_c = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] res_a;
  logic [2:0] res_b;
  logic [2:0] res_c;
  logic       err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rns_forward_converter #(.W_IN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .moduli_a  (moduli_a),
    .moduli_b  (moduli_b),
    .moduli_c  (moduli_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_a     (res_a),
    .res_b     (res_b),
    .res_c     (res_c),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input string tag, input logic [7:0] d,
                      input logic [2:0] ma, input logic [2:0] mb,
                      input logic [2:0] mc, input logic [2:0] ea,
                      input logic [2:0] eb, input logic [2:0] ec,
                      input logic ee, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 1);
    out_ready = (hold == 0);
    in_valid = 1'b1;
    in_data  = d;
    moduli_a = ma;
    moduli_b = mb;
    moduli_c = mc;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    chk({tag, "_busy"}, 32'(in_ready), 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) chk({tag, "_early"}, 32'(out_valid), 0);
    end
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_res"}, {res_a, res_b, res_c, 3'b0, ee ? err : err},
        {ea, eb, ec, 3'b0, ee});
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      in_data  = 8'(h * 37);
      tick();
      chk({tag, "_hold"},
          {out_valid, in_ready, res_a, res_b, res_c, err},
          {1'b1, 1'b0, ea, eb, ec, ee});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({tag, "_handshake"}, {out_valid, in_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    logic [7:0] d;
    logic [2:0] ma;
    logic [2:0] mb;
    logic [2:0] mc;
    tick();
    tick();
    chk("reset_state",
        {in_ready, out_valid, res_a, res_b, res_c, err},
        {1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0});
    rst_n = 1'b1;
    tick();

    conv("nominal", 8'd100, 3'd7, 3'd5, 3'd3, 3'd2, 3'd0, 3'd1, 1'b0, 0);
    conv("full", 8'd255, 3'd7, 3'd5, 3'd3, 3'd3, 3'd0, 3'd0, 1'b0, 0);
    conv("zero", 8'd0, 3'd7, 3'd6, 3'd4, 3'd0, 3'd0, 3'd0, 1'b0, 0);
    conv("degen", 8'd13, 3'd1, 3'd0, 3'd7, 3'd0, 3'd0, 3'd6, 1'b1, 0);
    conv("after_degen", 8'd13, 3'd2, 3'd3, 3'd4,
         3'd1, 3'd1, 3'd1, 1'b0, 0);
    conv("backpressure", 8'd77, 3'd5, 3'd6, 3'd7,
         3'd2, 3'd5, 3'd0, 1'b0, 10);

    in_valid = 1'b1;
    in_data  = 8'd200;
    moduli_a = 3'd7;
    moduli_b = 3'd5;
    moduli_c = 3'd3;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_reset",
        {in_ready, out_valid, res_a, res_b, res_c, err},
        {1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0});
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0) chk("stale_valid", 32'(out_valid), 0);
    end
    conv("post_reset", 8'd200, 3'd7, 3'd5, 3'd3,
         3'd4, 3'd0, 3'd2, 1'b0, 0);

    for (int k = 0; k < 100; k++) begin
      d  = 8'($urandom_range(0, 255));
      ma = 3'($urandom_range(1, 7));
      mb = 3'($urandom_range(1, 7));
      mc = 3'($urandom_range(1, 7));
      repeat ($urandom_range(0, 2)) tick();
      conv("random", d, ma, mb, mc,
           3'(d % ma), 3'(d % mb), 3'(d % mc), 1'b0,
           int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
